// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults and FSM state encoding for the fetch stage
package fetch_pkg;

  localparam int          DEF_ADDR_WIDTH = 32;
  localparam int          DEF_DATA_WIDTH = 32;
  localparam int          DEF_FIFO_DEPTH = 2;
  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
  localparam int unsigned DEF_PC_STEP    = 4;

  typedef enum logic [0:0] {
    FS_REQ  = 1'b0,
    FS_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [0:0] REQ  = FS_REQ;
  localparam logic [0:0] WAIT = FS_WAIT;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - instruction memory request/response and decode-side instruction stream
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  memReqValid;
  logic [ADDR_WIDTH-1:0] memReqAddr;
  logic                  memReqReady;
  logic                  memRespValid;
  logic [DATA_WIDTH-1:0] memRespData;
  logic                  instrValid;
  logic [DATA_WIDTH-1:0] instrData;
  logic [ADDR_WIDTH-1:0] instrAddr;
  logic                  instrReady;

  modport master (
    output memReqValid, memReqAddr,
    input  memReqReady, memRespValid, memRespData,
    output instrValid, instrData, instrAddr,
    input  instrReady
  );

  modport slave (
    input  memReqValid, memReqAddr,
    output memReqReady, memRespValid, memRespData,
    input  instrValid, instrData, instrAddr,
    output instrReady
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with clear; head word is visible combinationally
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, single-outstanding fetch FSM and instruction buffer
// Optional FETCH_STATS_EN adds saturating statFetched/statStalls counters.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(DEF_RESET_ADDR),
  parameter int unsigned           PC_STEP    = DEF_PC_STEP,
  parameter int                    FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addressIn,
  input  logic                  branchTaken,
  output logic [ADDR_WIDTH-1:0] addressNorm,
  output logic [ADDR_WIDTH-1:0] pcCurrent,
`ifdef FETCH_STATS_EN
  output logic [31:0]           statFetched,
  output logic [31:0]           statStalls,
`endif
  instruction_fetch_if.master   bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0]            pc;
  logic [ADDR_WIDTH-1:0]            req_addr;
  logic [0:0]                       state;
  logic                             drop_pending;
  logic [CW-1:0]                    fifo_count;
  logic                             fifo_push;
  logic                             fifo_pop;
  logic                             req_fire;
  logic                             resp_fire;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_head;

  assign addressNorm = pc + ADDR_WIDTH'(PC_STEP);
  assign pcCurrent   = pc;

  // Only one request is ever in flight, so a free slot now guarantees room for its response.
  assign bus.memReqValid = !rst && (state == REQ) && (fifo_count < CW'(FIFO_DEPTH));
  assign bus.memReqAddr  = pc;

  assign req_fire  = bus.memReqValid && bus.memReqReady;
  assign resp_fire = (state == WAIT) && bus.memRespValid;
  assign fifo_push = resp_fire && !drop_pending && !branchTaken;
  assign fifo_pop  = bus.instrValid && bus.instrReady && !branchTaken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= RESET_ADDR;
      req_addr     <= '0;
      state        <= REQ;
      drop_pending <= 1'b0;
    end else begin
      if (branchTaken || req_fire) pc <= addressIn;
      case (state)
        REQ: begin
          if (req_fire) begin
            req_addr     <= pc;
            state        <= WAIT;
            drop_pending <= branchTaken;
          end
        end
        WAIT: begin
          // A redirect alongside the response just discards it; nothing is left to drop.
          if (bus.memRespValid) begin
            state        <= REQ;
            drop_pending <= 1'b0;
          end else if (branchTaken) begin
            drop_pending <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({req_addr, bus.memRespData}),
    .pop       (fifo_pop),
    .clear     (branchTaken),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  assign bus.instrValid                  = (fifo_count != '0);
  assign {bus.instrAddr, bus.instrData}  = fifo_head;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statFetched <= '0;
      statStalls  <= '0;
    end else begin
      if (fifo_push && (statFetched != '1)) statFetched <= statFetched + 32'd1;
      if (bus.memReqValid && !bus.memReqReady && (statStalls != '1)) statStalls <= statStalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addressIn;
  logic        branchTaken;
  logic [31:0] addressNorm;
  logic [31:0] pcCurrent;
`ifdef FETCH_STATS_EN
  logic [31:0] statFetched;
  logic [31:0] statStalls;
`endif

  instruction_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .addressIn   (addressIn),
    .branchTaken (branchTaken),
    .addressNorm (addressNorm),
    .pcCurrent   (pcCurrent),
`ifdef FETCH_STATS_EN
    .statFetched (statFetched),
    .statStalls  (statStalls),
`endif
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // reference model: architectural PC, one outstanding fetch, buffered words = exp_q
  logic [31:0] m_pc;
  bit          m_out, m_drop;
  logic [31:0] m_req_addr, m_req_data;
  int          m_wait, m_seq, m_fetched, m_stalls;

  bit          p_fire, p_resp, p_br, p_stall;
  logic [31:0] p_addr_in;

  int          ready_pct = 100, instr_ready_pct = 100, br_pct = 0, dly_min = 1, dly_max = 1;
  int          br_mode = 0;      // 1: redirect while waiting without response, 2: redirect with response
  logic [31:0] br_target = 32'h0;
  int          stall_left = 0;
  bit          want_rst = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = 32'h0; m_out = 0; m_drop = 0; m_wait = 0;
    m_seq = 0; m_fetched = 0; m_stalls = 0;
    p_fire = 0; p_resp = 0; p_br = 0; p_stall = 0; p_addr_in = 32'h0;
  endtask

  task automatic cycle();
    bit ev, resp, br, fire;
    @(negedge clk); #1;
    if (!rst) begin
      if (p_stall) m_stalls++;
      if (p_fire) begin
        m_out = 1; m_drop = p_br; m_req_addr = m_pc;
        m_req_data = 32'hA0 + m_seq; m_seq++;
        m_wait = $urandom_range(dly_max, dly_min);
      end
      if (p_resp) begin
        if (!m_drop && !p_br) begin
          exp_q.push_back('{m_req_addr, m_req_data});
          m_fetched++;
        end
        m_out = 0; m_drop = 0;
      end else if (m_out && p_br && !p_fire) begin
        m_drop = 1;
      end
      if (p_br) exp_q.delete();
      if (p_fire || p_br) m_pc = p_addr_in;
    end
    if (want_rst) begin
      rst = 1'b1;
      model_reset();
    end else begin
      rst = 1'b0;
    end
    ev   = !rst && !m_out && (exp_q.size() < 2);
    resp = m_out && (m_wait == 1);
    if (m_out && !resp) m_wait--;
    if (stall_left > 0 && ev) begin
      bus.memReqReady = 1'b0;
      stall_left--;
    end else begin
      bus.memReqReady = ($urandom_range(99) < ready_pct);
    end
    bus.memRespValid = resp;
    bus.memRespData  = resp ? m_req_data : $urandom();
    bus.instrReady   = ($urandom_range(99) < instr_ready_pct);
    br = 0;
    if (!rst) begin
      if (br_mode == 1 && m_out && !resp) begin br = 1; br_mode = 0; end
      else if (br_mode == 2 && resp) begin br = 1; br_mode = 0; end
      else if ($urandom_range(99) < br_pct) begin
        br = 1; br_target = $urandom() & 32'hFFFF_FFFC;
      end
    end
    branchTaken = br;
    addressIn   = br ? br_target : m_pc + 32'd4;
    fire    = ev && bus.memReqReady;
    p_fire  = fire;
    p_resp  = resp;
    p_br    = br;
    p_addr_in = addressIn;
    p_stall = ev && !bus.memReqReady;
  endtask

  // monitor: compares DUT outputs with the model just before each active edge
  initial begin
    logic [31:0] norm;
    bit          exp_valid;
    forever begin
      @(negedge clk); #3;
      norm      = m_pc + 32'd4;
      exp_valid = !rst && !m_out && (exp_q.size() < 2);
      chk("memReqValid", 64'(bus.memReqValid), 64'(exp_valid));
      chk("pcCurrent", 64'(pcCurrent), 64'(m_pc));
      chk("addressNorm", 64'(addressNorm), 64'(norm));
      if (exp_valid) chk("memReqAddr", 64'(bus.memReqAddr), 64'(m_pc));
      chk("instrValid", 64'(bus.instrValid), 64'(exp_q.size() != 0));
      if (bus.instrValid && exp_q.size() != 0) begin
        chk("instrAddr", 64'(bus.instrAddr), 64'(exp_q[0].addr));
        chk("instrData", 64'(bus.instrData), 64'(exp_q[0].data));
        if (bus.instrReady && !branchTaken) void'(exp_q.pop_front());
      end
`ifdef FETCH_STATS_EN
      chk("statFetched", 64'(statFetched), 64'(m_fetched));
      chk("statStalls", 64'(statStalls), 64'(m_stalls));
`endif
    end
  end

  task automatic run_mode(input int mode, input logic [31:0] target, input string name);
    int n;
    br_mode = mode; br_target = target; n = 0;
    while (br_mode != 0 && n < 40) begin cycle(); n++; end
    if (br_mode != 0) begin
      errors++;
      $display("FAIL %s: redirect window not reached within 40 cycles", name);
      br_mode = 0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; branchTaken = 1'b0; addressIn = 32'h0;
    bus.memReqReady = 1'b0; bus.memRespValid = 1'b0; bus.memRespData = 32'h0; bus.instrReady = 1'b0;
    model_reset();

    // reset, then sequential fetch A0,A1,A2... from 0,4,8
    want_rst = 1; repeat (2) cycle();
    want_rst = 0; repeat (12) cycle();

    // decode stalled: buffer fills to two words and requests stop
    instr_ready_pct = 0; repeat (10) cycle();
    instr_ready_pct = 100; repeat (8) cycle();

    // redirect while waiting, then redirect together with the response
    dly_min = 2; dly_max = 2;
    run_mode(1, 32'h0000_0100, "redirect_wait"); repeat (8) cycle();
    run_mode(2, 32'h0000_0200, "redirect_resp"); repeat (8) cycle();
    run_mode(1, 32'hFFFF_FFF8, "redirect_wrap"); repeat (10) cycle();

    // three stalled request cycles
    dly_min = 1; dly_max = 1;
    stall_left = 3; repeat (10) cycle();

    // reset while waiting with one word buffered
    instr_ready_pct = 0; dly_min = 3; dly_max = 3; n = 0;
    while (!(m_out && exp_q.size() == 1) && n < 40) begin cycle(); n++; end
    if (n >= 40) begin errors++; $display("FAIL rst_window: not reached within 40 cycles"); end
    want_rst = 1; cycle();
    want_rst = 0; instr_ready_pct = 100; dly_min = 1; dly_max = 1; repeat (10) cycle();

    // randomized traffic
    ready_pct = 70; instr_ready_pct = 60; br_pct = 6; dly_min = 1; dly_max = 3;
    repeat (400) cycle();
    ready_pct = 100; instr_ready_pct = 100; br_pct = 0; repeat (12) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
